// File: rtl/ser_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
package ser_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic parity_bit(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-time counter: pulses bit_end on the last clock of every serial bit.
module ser_bit_timer
  import ser_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic bit_end
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign bit_end = run && (r_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RST || !run)  r_cnt <= '0;
    else if (bit_end) r_cnt <= '0;
    else              r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/ser_tx_frame.sv
// Serial frame transmitter: start bit, DATA_W data bits, optional parity, stop bits.
// Parity bit is compiled in only when SER_TX_PARITY_EN is defined.
module ser_tx_frame
  import ser_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int LSB_FIRST    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              data_out,
  output logic              busy,
  output logic              done
);

  localparam int IW = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  if (DATA_W < 1 || DATA_W > 32 || CLKS_PER_BIT < 1 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_bad_param
    $error("ser_tx_frame: parameter out of range");
  end

  state_t            r_state, w_nxt_state;
  logic [DATA_W-1:0] r_shift, w_nxt_shift, w_shifted;
  logic [IW-1:0]     r_idx, w_nxt_idx;
  logic              r_stop, w_nxt_stop;
  logic              r_dout, w_nxt_dout;
  logic              r_ready, w_nxt_ready;
  logic              r_busy, w_nxt_busy;
  logic              r_done, w_nxt_done;
  logic              w_bit_end;
  logic              w_first_cur, w_first_sh;
`ifdef SER_TX_PARITY_EN
  logic              r_par, w_nxt_par;
`endif

  ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .run     (r_state != S_IDLE),
    .bit_end (w_bit_end)
  );

  // Next bit on the line is always the "front" of the shift register.
  assign w_shifted   = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
  assign w_first_cur = (LSB_FIRST != 0) ? r_shift[0]   : r_shift[DATA_W-1];
  assign w_first_sh  = (LSB_FIRST != 0) ? w_shifted[0] : w_shifted[DATA_W-1];

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_shift = r_shift;
    w_nxt_idx   = r_idx;
    w_nxt_stop  = r_stop;
    w_nxt_dout  = r_dout;
    w_nxt_ready = 1'b0;
    w_nxt_busy  = 1'b1;
    w_nxt_done  = 1'b0;
`ifdef SER_TX_PARITY_EN
    w_nxt_par   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_nxt_ready = 1'b1;
        w_nxt_busy  = 1'b0;
        w_nxt_dout  = 1'b1;
        if (valid_in && r_ready) begin
          w_nxt_shift = data_in;
`ifdef SER_TX_PARITY_EN
          w_nxt_par   = parity_bit(32'(data_in), PARITY_ODD[0]);
`endif
          w_nxt_idx   = '0;
          w_nxt_stop  = 1'b0;
          w_nxt_dout  = 1'b0;
          w_nxt_ready = 1'b0;
          w_nxt_busy  = 1'b1;
          w_nxt_state = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_nxt_state = S_DATA;
          w_nxt_dout  = w_first_cur;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == LAST_IDX) begin
`ifdef SER_TX_PARITY_EN
            w_nxt_state = S_PARITY;
            w_nxt_dout  = r_par;
`else
            w_nxt_state = S_STOP;
            w_nxt_dout  = 1'b1;
`endif
          end else begin
            w_nxt_idx   = r_idx + 1'b1;
            w_nxt_shift = w_shifted;
            w_nxt_dout  = w_first_sh;
          end
        end
      end
`ifdef SER_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_nxt_state = S_STOP;
          w_nxt_dout  = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop == LAST_STOP) begin
            w_nxt_state = S_IDLE;
            w_nxt_ready = 1'b1;
            w_nxt_busy  = 1'b0;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_stop = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_dout  = 1'b1;
        w_nxt_ready = 1'b1;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
      r_dout  <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SER_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_shift <= w_nxt_shift;
      r_idx   <= w_nxt_idx;
      r_stop  <= w_nxt_stop;
      r_dout  <= w_nxt_dout;
      r_ready <= w_nxt_ready;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
`ifdef SER_TX_PARITY_EN
      r_par   <= w_nxt_par;
`endif
    end
  end

  assign ready_out = r_ready;
  assign data_out  = r_dout;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ser_tx_frame.sv
// Directed bench for ser_tx_frame; four instances cover parity sense, stop bits and bit order.
module tb_ser_tx_frame;

  localparam int C = 4;
`ifdef SER_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       valid [4];
  logic [7:0] din   [4];
  logic       ready [4];
  logic       dout  [4];
  logic       busy  [4];
  logic       done  [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  ser_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(0), .LSB_FIRST(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .data_in(din[0]), .valid_in(valid[0]),
    .ready_out(ready[0]), .data_out(dout[0]), .busy(busy[0]), .done(done[0]));
  ser_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(1), .LSB_FIRST(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .data_in(din[1]), .valid_in(valid[1]),
    .ready_out(ready[1]), .data_out(dout[1]), .busy(busy[1]), .done(done[1]));
  ser_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_ODD(0), .LSB_FIRST(1)) u_dut2 (
    .CLK(CLK), .RST(RST), .data_in(din[2]), .valid_in(valid[2]),
    .ready_out(ready[2]), .data_out(dout[2]), .busy(busy[2]), .done(done[2]));
  ser_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(0), .LSB_FIRST(0)) u_dut3 (
    .CLK(CLK), .RST(RST), .data_in(din[3]), .valid_in(valid[3]),
    .ready_out(ready[3]), .data_out(dout[3]), .busy(busy[3]), .done(done[3]));

  // line: data bits in the order they appear on the wire (bit 0 first)
  typedef struct {
    int         k;
    logic [7:0] data;
    logic [7:0] line;
    logic       par;
    int         stops;
    int         pulse_at;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %b, expected %b", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] build_seq(input logic [7:0] line, input logic par);
    logic [15:0] s;
    s    = '1;
    s[0] = 1'b0;
    for (int i = 0; i < 8; i++) s[1+i] = line[i];
    if (P == 1) s[9] = par;
    return s;
  endfunction

  // Entered at the falling edge of the first frame cycle; leaves at the done cycle.
  task automatic check_frame(input int k, input logic [15:0] seq, input int nbits, input int pulse_at);
    for (int j = 0; j < nbits * C; j++) begin
      if (j == pulse_at) begin
        valid[k] = 1'b1;
        din[k]   = 8'h3C;
      end else if (pulse_at >= 0 && j == pulse_at + 1) begin
        valid[k] = 1'b0;
      end
      chk("line",  k, dout[k],  seq[j / C]);
      chk("busy",  k, busy[k],  1'b1);
      chk("ready", k, ready[k], 1'b0);
      chk("done",  k, done[k],  1'b0);
      @(negedge CLK);
    end
    chk("done_pulse",  k, done[k],  1'b1);
    chk("ready_back",  k, ready[k], 1'b1);
    chk("busy_clear",  k, busy[k],  1'b0);
    chk("idle_line",   k, dout[k],  1'b1);
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic [15:0] seq, input int nbits,
                      input int pulse_at);
    chk("ready_pre", k, ready[k], 1'b1);
    din[k]   = d;
    valid[k] = 1'b1;
    @(negedge CLK);
    valid[k] = 1'b0;
    check_frame(k, seq, nbits, pulse_at);
    @(negedge CLK);
    chk("done_clear", k, done[k], 1'b0);
    chk("no_queue",   k, busy[k], 1'b0);
    chk("idle_line2", k, dout[k], 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 8'hA5, 8'hA5, 1'b0, 1, -1};
    tbl[1] = '{1, 8'h01, 8'h01, 1'b0, 1, -1};
    tbl[2] = '{0, 8'h01, 8'h01, 1'b1, 1, -1};
    tbl[3] = '{2, 8'hA5, 8'hA5, 1'b0, 2, -1};
    tbl[4] = '{3, 8'h80, 8'h01, 1'b1, 1, -1};
    tbl[5] = '{0, 8'hFF, 8'hFF, 1'b0, 1, -1};
    tbl[6] = '{3, 8'h0F, 8'hF0, 1'b0, 1, -1};
    tbl[7] = '{1, 8'h00, 8'h00, 1'b1, 1, 13};
    tbl[8] = '{2, 8'h3C, 8'h3C, 1'b0, 2, -1};

    // Reset with valid asserted: reset must win.
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid[k] = 1'b1;
      din[k]   = 8'hFF;
    end
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      chk("rst_line",  k, dout[k],  1'b1);
      chk("rst_ready", k, ready[k], 1'b1);
      chk("rst_busy",  k, busy[k],  1'b0);
      chk("rst_done",  k, done[k],  1'b0);
      valid[k] = 1'b0;
    end
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 9; i++)
      send(tbl[i].k, tbl[i].data, build_seq(tbl[i].line, tbl[i].par),
           1 + 8 + P + tbl[i].stops, tbl[i].pulse_at);

    // Back-to-back: valid held high, second word taken in the done cycle.
    chk("ready_pre", 0, ready[0], 1'b1);
    din[0]   = 8'h11;
    valid[0] = 1'b1;
    @(negedge CLK);
    din[0] = 8'h22;
    check_frame(0, build_seq(8'h11, 1'b0), 1 + 8 + P + 1, -1);
    @(negedge CLK);
    valid[0] = 1'b0;
    check_frame(0, build_seq(8'h22, 1'b0), 1 + 8 + P + 1, -1);
    @(negedge CLK);
    chk("done_clear", 0, done[0], 1'b0);

    // Reset in the middle of data bit 3 aborts the frame.
    din[0]   = 8'hC3;
    valid[0] = 1'b1;
    @(negedge CLK);
    valid[0] = 1'b0;
    repeat (17) @(negedge CLK);
    chk("pre_rst_busy", 0, busy[0], 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_line",  0, dout[0],  1'b1);
    chk("abort_ready", 0, ready[0], 1'b1);
    chk("abort_busy",  0, busy[0],  1'b0);
    chk("abort_done",  0, done[0],  1'b0);
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      chk("abort_nodone", 0, done[0], 1'b0);
      chk("abort_idle",   0, dout[0], 1'b1);
    end
    send(0, 8'h5A, build_seq(8'h5A, 1'b0), 1 + 8 + P + 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
